mem_req_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester. It grants one requester at a time and registers the address-phase request toward memory. It records each accepted request's owner in an in-order tracking FIFO and routes every returning data_ok/rdata to that owner. It sits between the IF/EX stages and the memory interface. The MEM stage consumes the data-side rdata it returns.

---
 rtl/mem_req_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-requester (fetch / load-store) arbiter for one SRAM-like memory port with
// an in-order owner FIFO for response routing. Define ARB_RR_EN for round-robin.
module mem_req_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int PW = $clog2(OT_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(OT_DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  state_t        state, state_nxt;
  mem_cmd_t      cmd, cmd_win;
  logic          grant_id;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [OT_DEPTH-1:0] owner_q;
  logic          grant, pick_data, push, pop, head;

  assign grant = (state == IDLE) && (count < DEPTH_C) && (inst_req || data_req);
  assign push  = (state == BUSY) && mem_addr_ok;
  assign pop   = mem_data_ok && (count != '0);
  assign head  = owner_q[rd_ptr];

`ifdef ARB_RR_EN
  // On contention, favour whoever did not win the previous grant.
  logic last_grant;
  assign pick_data = data_req && (!inst_req || !last_grant);
  always_ff @(posedge clk) begin
    if (!resetn)    last_grant <= 1'b0;
    else if (grant) last_grant <= pick_data;
  end
`else
  assign pick_data = data_req;
`endif

  // Fetches are always plain word reads.
  always_comb begin
    if (pick_data) cmd_win = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                               addr: data_addr, wdata: data_wdata};
    else           cmd_win = '{wr: 1'b0, size: 2'd2, wstrb: 4'd0,
                               addr: inst_addr, wdata: 32'd0};
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant)       state_nxt = BUSY;
      BUSY: if (mem_addr_ok) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req      = (state == BUSY);
    inst_addr_ok = push && !grant_id;
    data_addr_ok = push &&  grant_id;
    inst_data_ok = pop  && !head;
    data_data_ok = pop  &&  head;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd      <= '0;
      grant_id <= 1'b0;
    end else if (grant) begin
      cmd      <= cmd_win;
      grant_id <= pick_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      owner_q <= '0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= grant_id;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign mem_wr     = cmd.wr;
  assign mem_size   = cmd.size;
  assign mem_wstrb  = cmd.wstrb;
  assign mem_addr   = cmd.addr;
  assign mem_wdata  = cmd.wdata;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model. Honours ARB_RR_EN like the design.
module tb_mem_req_arbiter;
  localparam int D = 4;

  logic clk = 1'b0, resetn = 1'b0;
  logic inst_req = 0, data_req = 0, data_wr = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic [1:0] data_size = 0;
  logic [3:0] data_wstrb = 0;
  logic mem_addr_ok = 0, mem_data_ok = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic mem_req, mem_wr;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;

  int nvec = 0, nerr = 0;

  mem_req_arbiter #(.OT_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change 1 after the edge; outputs are sampled 1 later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; data_req = 0; data_wr = 0; inst_addr = 0; data_addr = 0;
    data_wdata = 0; data_size = 0; data_wstrb = 0; mem_addr_ok = 0;
    mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  // Drive one request through its address phase; returns the addr_ok seen.
  task automatic accept(input bit d, input logic [31:0] a, output bit ok);
    if (d) begin data_req = 1; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = a; end
    else   begin inst_req = 1; inst_addr = a; end
    tick();
    mem_addr_ok = 1; #1;
    ok = d ? data_addr_ok : inst_addr_ok;
    tick();
    mem_addr_ok = 0; inst_req = 0; data_req = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    mem_rdata = 32'hA5A5_0001; #1;
    nvec++; if ({mem_req, mem_wr, mem_size, mem_wstrb} !== 8'h00) begin nerr++;
      $display("FAIL reset_ctrl: got req=%b wr=%b size=%0d wstrb=%h want all 0", mem_req, mem_wr, mem_size, mem_wstrb); end
    nvec++; if ({mem_addr, mem_wdata} !== 64'h0) begin nerr++;
      $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata); end
    nvec++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) begin nerr++;
      $display("FAIL reset_handshakes: got %b want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
    nvec++; if (inst_rdata !== 32'hA5A5_0001 || data_rdata !== 32'hA5A5_0001) begin nerr++;
      $display("FAIL reset_rdata: got %h/%h want a5a50001", inst_rdata, data_rdata); end
    mem_rdata = 0;
  endtask

  task automatic test_single_fetch();
    int req_cycles = 0, iok = 0, idok = 0, ddok = 0;
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; #1;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL fetch_req_early: got %b want 0", mem_req); end
    tick(); #1;
    nvec++; if (mem_addr !== 32'h1C00_0000 || mem_wr !== 1'b0 || mem_size !== 2'd2 || mem_wstrb !== 4'd0) begin nerr++;
      $display("FAIL fetch_fields: got addr=%h wr=%b size=%0d wstrb=%h want 1c000000/0/2/0", mem_addr, mem_wr, mem_size, mem_wstrb); end
    mem_addr_ok = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      req_cycles += int'(mem_req); iok += int'(inst_addr_ok);
      idok += int'(inst_data_ok); ddok += int'(data_data_ok);
      if (inst_data_ok) begin
        nvec++; if (inst_rdata !== 32'h0280_0C0C) begin nerr++;
          $display("FAIL fetch_rdata: got %h want 02800c0c", inst_rdata); end
      end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
      if (c == 2) begin mem_data_ok = 1; mem_rdata = 32'h0280_0C0C; end
    end
    nvec++; if (req_cycles != 1 || iok != 1) begin nerr++;
      $display("FAIL fetch_addr_phase: got req_cycles=%0d addr_ok=%0d want 1/1", req_cycles, iok); end
    nvec++; if (idok != 1 || ddok != 0) begin nerr++;
      $display("FAIL fetch_data_ok: got inst=%0d data=%0d want 1/0", idok, ddok); end
  endtask

  task automatic test_contention();
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0040;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h100; data_wdata = 32'h1234_5678;
    tick(); #1;
    nvec++; if (mem_addr !== 32'h100 || mem_wr !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF) begin nerr++;
      $display("FAIL contend_first: got addr=%h wr=%b wdata=%h wstrb=%h want 100/1/12345678/f", mem_addr, mem_wr, mem_wdata, mem_wstrb); end
    mem_addr_ok = 1; #1;
    nvec++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin nerr++;
      $display("FAIL contend_first_ok: got data=%b inst=%b want 1/0", data_addr_ok, inst_addr_ok); end
    tick();
    mem_addr_ok = 0;
`ifdef ARB_RR_EN
    data_wr = 0; data_wstrb = 0; data_wdata = 0; data_addr = 32'h200;
`else
    data_req = 0;
`endif
    #1;
    nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL contend_gap: got %b want 0", mem_req); end
    tick(); #1;
    nvec++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0040 || mem_wr !== 1'b0) begin nerr++;
      $display("FAIL contend_second: got req=%b addr=%h wr=%b want 1/1c000040/0", mem_req, mem_addr, mem_wr); end
    mem_addr_ok = 1; #1;
    nvec++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin nerr++;
      $display("FAIL contend_second_ok: got inst=%b data=%b want 1/0", inst_addr_ok, data_addr_ok); end
    tick();
    mem_addr_ok = 0; inst_req = 0;
`ifdef ARB_RR_EN
    tick(); #1;
    nvec++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin nerr++;
      $display("FAIL contend_third: got req=%b addr=%h want 1/200", mem_req, mem_addr); end
`endif
    clear_inputs();
  endtask

  task automatic test_full_fifo();
    int n = 0;
    bit rose = 0;
    apply_reset();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h400; mem_addr_ok = 1;
    for (int c = 0; c < 14; c++) begin
      #1; n += int'(data_addr_ok); tick();
    end
    #1;
    nvec++; if (n != D || mem_req !== 1'b0) begin nerr++;
      $display("FAIL full_accepts: got accepts=%0d mem_req=%b want %0d/0", n, mem_req, D); end
    mem_data_ok = 1; mem_rdata = 32'hDEAD_0004; #1;
    nvec++; if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0) begin nerr++;
      $display("FAIL full_pop: got data_ok=%b addr_ok=%b want 1/0", data_data_ok, data_addr_ok); end
    tick(); mem_data_ok = 0;
    for (int c = 0; c < 3 && !rose; c++) begin
      #1; rose = mem_req; if (!rose) tick();
    end
    nvec++; if (!rose) begin nerr++; $display("FAIL full_resume: got mem_req=0 after pop want 1"); end
    clear_inputs();
  endtask

  task automatic test_ordering();
    bit ok;
    bit own [3] = '{0, 1, 0};
    logic [31:0] rd [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      accept(own[i], 32'h1000 + 32'(i) * 4, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL order_accept%0d: got addr_ok=0 want 1", i); end
    end
    for (int i = 0; i < 3; i++) begin
      mem_data_ok = 1; mem_rdata = rd[i]; #1;
      nvec++; if (inst_data_ok !== !own[i] || data_data_ok !== own[i] ||
                  (own[i] ? data_rdata : inst_rdata) !== rd[i]) begin nerr++;
        $display("FAIL order_resp%0d: got inst_ok=%b data_ok=%b rdata=%h want owner=%0d rdata=%h",
                 i, inst_data_ok, data_data_ok, own[i] ? data_rdata : inst_rdata, own[i], rd[i]); end
      tick(); mem_data_ok = 0;
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    apply_reset();
    accept(0, 32'h10, ok); accept(1, 32'h20, ok); accept(0, 32'h30, ok);
    mem_data_ok = 1; #1;
    nvec++; if (inst_data_ok !== 1'b1) begin nerr++; $display("FAIL pp_pre_pop: got %b want 1", inst_data_ok); end
    tick(); mem_data_ok = 0;
    data_req = 1; data_addr = 32'h40; data_wr = 0;
    tick();
    mem_addr_ok = 1; mem_data_ok = 1; #1;
    nvec++; if (data_addr_ok !== 1'b1 || data_data_ok !== 1'b1) begin nerr++;
      $display("FAIL pp_same_cycle: got addr_ok=%b data_ok=%b want 1/1", data_addr_ok, data_data_ok); end
    tick(); mem_addr_ok = 0; mem_data_ok = 0; data_req = 0; #1;
    nvec++; if (dut.count !== 3'd2 || dut.wr_ptr !== 2'd0 || dut.rd_ptr !== 2'd2) begin nerr++;
      $display("FAIL pp_state: got count=%0d wr=%0d rd=%0d want 2/0/2", dut.count, dut.wr_ptr, dut.rd_ptr); end
    mem_data_ok = 1; #1;
    nvec++; if (inst_data_ok !== 1'b1) begin nerr++; $display("FAIL pp_pop2: got %b want 1", inst_data_ok); end
    tick(); #1;
    nvec++; if (data_data_ok !== 1'b1) begin nerr++; $display("FAIL pp_pop3: got %b want 1", data_data_ok); end
    tick(); mem_data_ok = 0; #1;
    nvec++; if (dut.count !== 3'd0 || dut.rd_ptr !== 2'd0) begin nerr++;
      $display("FAIL pp_drain: got count=%0d rd=%0d want 0/0", dut.count, dut.rd_ptr); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    accept(0, 32'h50, ok); accept(1, 32'h60, ok);
    data_req = 1; data_wr = 1; data_wstrb = 4'h3; data_size = 1; data_addr = 32'h70; data_wdata = 32'h77;
    tick(); #1;
    nvec++; if (mem_req !== 1'b1) begin nerr++; $display("FAIL rst_mid_busy: got %b want 1", mem_req); end
    resetn = 0; data_req = 0;
    tick(); #1;
    nvec++; if ({mem_req, mem_wr, mem_size, mem_wstrb} !== 8'h00 || {mem_addr, mem_wdata} !== 64'h0) begin nerr++;
      $display("FAIL rst_mid_outputs: got req=%b wr=%b size=%0d wstrb=%h addr=%h wdata=%h want all 0",
               mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata); end
    resetn = 1;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h5757_0000; #1;
    nvec++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin nerr++;
      $display("FAIL rst_stray: got inst=%b data=%b want 0/0", inst_data_ok, data_data_ok); end
    tick(); mem_data_ok = 0;
  endtask

  // Reference model: an owner queue plus the address-phase rules written as
  // "one grant at a time, at most D outstanding, a gap cycle between grants".
  task automatic test_random();
    bit q[$];
    bit busy = 0, own = 0, last = 0, hs, win, drop_i = 0, drop_d = 0, ei, ed;
    logic [31:0] e_addr = 0, e_wdata = 0;
    logic e_wr = 0;
    logic [1:0] e_size = 0;
    logic [3:0] e_wstrb = 0;
    int sz;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (drop_i) inst_req = 0;
      if (drop_d) data_req = 0;
      drop_i = 0; drop_d = 0;
      if (!inst_req && $urandom_range(2) == 0) begin
        inst_req = 1; inst_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(2) == 0) begin
        data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(2));
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      mem_addr_ok = 1'($urandom);
      mem_data_ok = (q.size() > 0) ? 1'($urandom) : ($urandom_range(15) == 0);
      mem_rdata   = $urandom;
      #1;
      hs = busy && mem_addr_ok;
      ei = mem_data_ok && q.size() > 0 && q[0] == 1'b0;
      ed = mem_data_ok && q.size() > 0 && q[0] == 1'b1;
      nvec++; if (mem_req !== busy) begin nerr++;
        $display("FAIL rnd_mem_req c=%0d: got %b want %b", c, mem_req, busy); end
      if (busy) begin
        nvec++; if (mem_addr !== e_addr || mem_wr !== e_wr || mem_size !== e_size ||
                    mem_wstrb !== e_wstrb || mem_wdata !== e_wdata) begin nerr++;
          $display("FAIL rnd_fields c=%0d: got %h/%b/%0d/%h/%h want %h/%b/%0d/%h/%h", c,
                   mem_addr, mem_wr, mem_size, mem_wstrb, mem_wdata, e_addr, e_wr, e_size, e_wstrb, e_wdata); end
      end
      nvec++; if (inst_addr_ok !== (hs && !own) || data_addr_ok !== (hs && own)) begin nerr++;
        $display("FAIL rnd_addr_ok c=%0d: got %b%b want %b%b", c, inst_addr_ok, data_addr_ok, hs && !own, hs && own); end
      nvec++; if (inst_data_ok !== ei || data_data_ok !== ed || inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin nerr++;
        $display("FAIL rnd_data_ok c=%0d: got %b%b want %b%b", c, inst_data_ok, data_data_ok, ei, ed); end
      sz = q.size();
      if (mem_data_ok && sz > 0) void'(q.pop_front());
      if (hs) begin
        q.push_back(own); busy = 0;
        if (own) drop_d = 1; else drop_i = 1;
      end else if (!busy && (inst_req || data_req) && sz < D) begin
`ifdef ARB_RR_EN
        win = (inst_req && data_req) ? !last : data_req;
`else
        win = data_req;
`endif
        last = win; own = win; busy = 1;
        if (win) begin e_addr = data_addr; e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb; e_wdata = data_wdata; end
        else     begin e_addr = inst_addr; e_wr = 0; e_size = 2; e_wstrb = 0; e_wdata = 0; end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_full_fifo();
    test_ordering();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
